// File: rtl/rdm_sequencer_if.sv
// Byte-stream handshake between the RDM sequencer and the UART transmitter.
// The master drives tx_valid/tx_data and the slave answers with tx_ready.
interface rdm_sequencer_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/rdm_sequencer.sv
// Subunit tracker that streams an 8-byte "RDM-<n>-#" message per deposit event.
// Optional transmit-stall abort is built when RDM_TIMEOUT_EN is defined.
module rdm_sequencer #(
  parameter int          NUM_SUBUNITS   = 4,
  parameter logic [7:0]  TERM_CHAR      = 8'h0A,
  parameter int          TIMEOUT_CYCLES = 50000000
) (
  input  logic           clk_50M,
  input  logic           rst_n,
  input  logic           mission_start,
  input  logic           deposit_done,
  rdm_sequencer_if.master tx,
  output logic [1:0]     subunit,
  output logic           RDM_active,
  output logic           mission_done,
  output logic           drop_err,
  output logic           tx_timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] LAST_SUB = 2'(NUM_SUBUNITS - 1);

  logic [1:0] state_q,    state_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic       pending_q,  pending_d;
  logic [1:0] subunit_q,  subunit_d;
  logic       drop_err_q, drop_err_d;
  logic       sending;
  logic       xfer;
  logic       stall_hit;
  logic [7:0] msg_byte;

  assign sending = (state_q == ST_SEND);
  assign xfer    = sending && tx.tx_ready;

`ifdef RDM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             tx_timeout_q, tx_timeout_d;

  // The final stall cycle aborts instead of counting, so the counter never overflows.
  assign stall_hit = sending && !tx.tx_ready &&
                     (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    stall_cnt_d = '0;
    if (sending && !tx.tx_ready && !stall_hit) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    tx_timeout_d = tx_timeout_q;
    if (stall_hit) begin
      tx_timeout_d = 1'b1;
    end else if (mission_start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      tx_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      tx_timeout_q <= 1'b0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign tx_timeout = tx_timeout_q;
`else
  assign stall_hit  = 1'b0;
  assign tx_timeout = 1'b0;
`endif

  always_comb begin
    case (byte_idx_q)
      3'd0:    msg_byte = 8'h52;
      3'd1:    msg_byte = 8'h44;
      3'd2:    msg_byte = 8'h4D;
      3'd3:    msg_byte = 8'h2D;
      3'd4:    msg_byte = 8'h31 + {6'b0, subunit_q};
      3'd5:    msg_byte = 8'h2D;
      3'd6:    msg_byte = 8'h23;
      default: msg_byte = TERM_CHAR;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    pending_d  = pending_q;
    subunit_d  = subunit_q;
    drop_err_d = drop_err_q;
    case (state_q)
      ST_IDLE: begin
        // A coincident deposit_done loses to mission_start and is silently discarded.
        if (mission_start) begin
          subunit_d  = 2'd0;
          drop_err_d = 1'b0;
        end else if (deposit_done || pending_q) begin
          state_d    = ST_SEND;
          pending_d  = 1'b0;
          byte_idx_d = 3'd0;
        end
      end
      ST_SEND: begin
        if (stall_hit) begin
          state_d    = ST_IDLE;
          byte_idx_d = 3'd0;
        end else if (xfer) begin
          byte_idx_d = byte_idx_q + 3'd1;
          if (byte_idx_q == 3'd7) begin
            if (subunit_q < LAST_SUB) begin
              subunit_d = subunit_q + 2'd1;
              state_d   = ST_IDLE;
            end else begin
              state_d   = ST_DONE;
            end
          end
        end
        if (deposit_done) begin
          if (!pending_q) begin
            pending_d  = 1'b1;
          end else begin
            drop_err_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (mission_start) begin
          state_d    = ST_IDLE;
          subunit_d  = 2'd0;
          pending_d  = 1'b0;
          drop_err_d = 1'b0;
        end else if (deposit_done) begin
          drop_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= 3'd0;
      pending_q  <= 1'b0;
      subunit_q  <= 2'd0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      pending_q  <= pending_d;
      subunit_q  <= subunit_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign tx.tx_valid  = sending;
  assign tx.tx_data   = sending ? msg_byte : 8'h00;
  assign RDM_active   = sending;
  assign mission_done = (state_q == ST_DONE);
  assign subunit      = subunit_q;
  assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_rdm_sequencer.sv
// Directed bench for rdm_sequencer: a byte scoreboard plus per-step output checks.
// Timeout steps are compiled only when RDM_TIMEOUT_EN is defined.
module tb_rdm_sequencer;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic       mission_start;
  logic       deposit_done;
  logic [1:0] subunit;
  logic       RDM_active;
  logic       mission_done;
  logic       drop_err;
  logic       tx_timeout;

  int vecs   = 0;
  int miscmp = 0;
  int xfers  = 0;
  logic [7:0] exp_q[$];

  rdm_sequencer_if txi ();

  rdm_sequencer #(
    .NUM_SUBUNITS   (4),
    .TERM_CHAR      (8'h0A),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_50M       (clk_50M),
    .rst_n         (rst_n),
    .mission_start (mission_start),
    .deposit_done  (deposit_done),
    .tx            (txi.master),
    .subunit       (subunit),
    .RDM_active    (RDM_active),
    .mission_done  (mission_done),
    .drop_err      (drop_err),
    .tx_timeout    (tx_timeout)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_msg(input int sub);
    logic [7:0] m [8];
    m = '{8'h52, 8'h44, 8'h4D, 8'h2D, 8'h00, 8'h2D, 8'h23, 8'h0A};
    m[4] = 8'(8'h31 + sub);
    for (int i = 0; i < 8; i++) exp_q.push_back(m[i]);
    $display("push message for subunit %0d", sub);
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic pulse_deposit();
    deposit_done = 1'b1;
    step();
    deposit_done = 1'b0;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (RDM_active && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic send_normal(input int sub);
    int n;
    push_msg(sub);
    pulse_deposit();
    chk("start_active", 32'(RDM_active), 32'd1);
    chk("start_subunit", 32'(subunit), 32'(sub));
    wait_end(n);
    chk("active_len", 32'(n), 32'd8);
  endtask

  always @(negedge clk_50M) begin
    if (rst_n === 1'b1) begin
      if (txi.tx_valid && txi.tx_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(txi.tx_data), 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("byte observed=%02h expected=%02h", txi.tx_data, e);
          chk("byte", 32'(txi.tx_data), 32'(e));
        end
      end else if (!txi.tx_valid) begin
        chk("idle_data", 32'(txi.tx_data), 32'd0);
      end
    end
  end

  initial begin
    int n;
    int x0;
    logic [7:0] held;
    logic was_stall;

    rst_n         = 1'b1;
    mission_start = 1'b0;
    deposit_done  = 1'b0;
    txi.tx_ready  = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_subunit", 32'(subunit), 32'd0);
    chk("rst_active", 32'(RDM_active), 32'd0);
    chk("rst_valid", 32'(txi.tx_valid), 32'd0);
    chk("rst_data", 32'(txi.tx_data), 32'd0);
    chk("rst_mdone", 32'(mission_done), 32'd0);
    chk("rst_drop", 32'(drop_err), 32'd0);
    chk("rst_tmo", 32'(tx_timeout), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    send_normal(0);
    chk("sub_after0", 32'(subunit), 32'd1);
    send_normal(1);
    send_normal(2);
    send_normal(3);
    chk("mdone", 32'(mission_done), 32'd1);
    chk("sub_hold3", 32'(subunit), 32'd3);
    step();
    chk("sub_hold3b", 32'(subunit), 32'd3);
    chk("done_idle", 32'(RDM_active), 32'd0);

    pulse_deposit();
    chk("done_drop", 32'(drop_err), 32'd1);
    chk("done_noact", 32'(RDM_active), 32'd0);
    mission_start = 1'b1;
    step();
    mission_start = 1'b0;
    chk("ms_sub", 32'(subunit), 32'd0);
    chk("ms_mdone", 32'(mission_done), 32'd0);
    chk("ms_drop", 32'(drop_err), 32'd0);

    push_msg(0);
    x0 = xfers;
    pulse_deposit();
    chk("stall_start", 32'(RDM_active), 32'd1);
    for (int i = 0; i < 100 && RDM_active; i++) begin
      txi.tx_ready = (i % 4 == 0) || (i % 4 == 3);
      held      = txi.tx_data;
      was_stall = !txi.tx_ready;
      step();
      if (was_stall) chk("stall_hold", 32'(txi.tx_data), 32'(held));
    end
    txi.tx_ready = 1'b1;
    chk("stall_xfers", 32'(xfers - x0), 32'd8);
    chk("stall_sub", 32'(subunit), 32'd1);

    push_msg(1);
    pulse_deposit();
    chk("pend_start", 32'(RDM_active), 32'd1);
    step();
    push_msg(2);
    pulse_deposit();
    chk("pend_nodrop", 32'(drop_err), 32'd0);
    step();
    pulse_deposit();
    chk("pend_drop", 32'(drop_err), 32'd1);
    wait_end(n);
    chk("pend_gap", 32'(RDM_active), 32'd0);
    chk("pend_gap_sub", 32'(subunit), 32'd2);
    step();
    chk("pend_restart", 32'(RDM_active), 32'd1);
    chk("pend_sub", 32'(subunit), 32'd2);
    wait_end(n);
    chk("pend_len", 32'(n), 32'd8);

    mission_start = 1'b1;
    deposit_done  = 1'b1;
    step();
    mission_start = 1'b0;
    deposit_done  = 1'b0;
    chk("coin_sub", 32'(subunit), 32'd0);
    chk("coin_drop", 32'(drop_err), 32'd0);
    chk("coin_act", 32'(RDM_active), 32'd0);
    step();
    chk("coin_act2", 32'(RDM_active), 32'd0);

    send_normal(0);
    push_msg(1);
    txi.tx_ready = 1'b0;
    pulse_deposit();
    chk("mid_start", 32'(RDM_active), 32'd1);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(txi.tx_valid), 32'd0);
    chk("arst_sub", 32'(subunit), 32'd0);
    chk("arst_act", 32'(RDM_active), 32'd0);
    chk("arst_data", 32'(txi.tx_data), 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    txi.tx_ready = 1'b1;
    step();

`ifdef RDM_TIMEOUT_EN
    send_normal(0);
    txi.tx_ready = 1'b0;
    pulse_deposit();
    chk("tmo_start", 32'(RDM_active), 32'd1);
    repeat (15) step();
    chk("tmo_pre_act", 32'(RDM_active), 32'd1);
    chk("tmo_pre_flag", 32'(tx_timeout), 32'd0);
    step();
    chk("tmo_flag", 32'(tx_timeout), 32'd1);
    chk("tmo_act", 32'(RDM_active), 32'd0);
    chk("tmo_sub", 32'(subunit), 32'd1);
    txi.tx_ready = 1'b1;
    step();
    chk("tmo_stay_idle", 32'(RDM_active), 32'd0);
`else
    chk("tmo_tied", 32'(tx_timeout), 32'd0);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/rdm_sequencer.md
Name: rdm_sequencer

Overview:
- Upstream stage of the resolved-detection logic.
- Tracks which subunit (0..NUM_SUBUNITS-1) the robot is servicing and, on each deposit-complete event, streams a fixed 8-byte Resource Deposition Message (RDM) to the UART transmitter through a valid/ready handshake.
- Drives `subunit` and `RDM_active` directly into the downstream resolved detector, which fires when the last subunit's message is in flight.

Parameters:
- NUM_SUBUNITS, 4, number of subunits per mission; legal range 2..4; last subunit index = NUM_SUBUNITS-1.
- TERM_CHAR, 8'h0A, final byte of every message.
- TIMEOUT_CYCLES, 50000000, consecutive tx_ready-low cycles before abort; used only with RDM_TIMEOUT_EN.

Ports:
- clk_50M  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mission_start  input  1  single-cycle pulse; re-arms the mission.
- deposit_done  input  1  single-cycle pulse; deposition at the current subunit finished.
- tx_ready  input  1  UART transmitter can accept a byte.
- tx_valid  output  1  byte on tx_data is valid.
- tx_data  output  8  message byte.
- subunit  output  2  current subunit index.
- RDM_active  output  1  high while the RDM for `subunit` is being sent.
- mission_done  output  1  high after the last subunit's message completes.
- drop_err  output  1  sticky; a deposit_done pulse was lost.
- tx_timeout  output  1  sticky transmit-stall flag (RDM_TIMEOUT_EN only).

Behaviour:
- Reset: one clock, clk_50M; reset is asynchronous and active-low on rst_n.
  - Outputs on reset: subunit=0, RDM_active=0, tx_valid=0, tx_data=8'h00, mission_done=0, drop_err=0, tx_timeout=0.
  - Internal on reset: state=IDLE, byte_idx=0, pending=0.
  - Reset mid-message abandons the message; no partial state survives.
- States: IDLE, SEND, DONE.
- IDLE:
  - Enters SEND next cycle if deposit_done is high or pending=1. Clears pending on entry.
  - RDM_active and tx_valid go high in the first SEND cycle, i.e. 1-cycle latency from deposit_done.
  - mission_start in IDLE sets subunit=0 and clears drop_err/tx_timeout.
  - If mission_start and deposit_done coincide in IDLE, mission_start wins and deposit_done is dropped; drop_err is not set.
- SEND:
  - Message bytes by byte_idx 0..7: "R", "D", "M", "-", 8'h31+subunit, "-", "#", TERM_CHAR. Example: subunit 2 sends "RDM-3-#\n".
  - A byte transfers when tx_valid && tx_ready; byte_idx then increments.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - On transfer of byte 7: RDM_active and tx_valid deassert next cycle.
    - If subunit < NUM_SUBUNITS-1: subunit increments and state goes to IDLE.
    - Else: subunit holds and state goes to DONE.
  - RDM_active is therefore low for at least 1 cycle between back-to-back messages.
  - deposit_done during SEND: if pending=0, set pending=1; if pending=1, the pulse is dropped and drop_err is set.
  - mission_start during SEND is ignored.
- DONE:
  - mission_done=1.
  - deposit_done is ignored and sets drop_err.
  - mission_start sets subunit=0, clears pending, mission_done, drop_err and tx_timeout, and goes to IDLE.
- tx_data = 8'h00 whenever tx_valid=0.
- No subunit wrap-around occurs except via mission_start.

Optional Feature:
- Macro RDM_TIMEOUT_EN.
  - Defined: a stall counter counts consecutive SEND cycles with tx_valid=1 && tx_ready=0, and clears on any transfer.
  - On reaching TIMEOUT_CYCLES, the message aborts: state goes to IDLE, byte_idx resets to 0, RDM_active=0, tx_timeout is set, subunit does NOT advance, pending is kept (retry via pending or the next deposit_done).
  - Undefined: SEND waits indefinitely, no counter is built, and tx_timeout is tied to 0.

Test Plan:
- Reset then deposit_done with tx_ready=1: RDM_active high 1 cycle later for exactly 8 cycles, bytes 52 44 4D 2D 31 2D 23 0A, then subunit=1.
- Four deposit_done pulses, each after the prior message completes: fourth message carries 8'h34 with subunit=3 and RDM_active=1 (downstream resolved=1 for 8 cycles); then mission_done=1 and subunit stays 3.
- tx_ready toggled 1-0-0-1 during SEND: tx_data holds during the stalls, no byte is duplicated or skipped, total 8 transfers.
- Two deposit_done pulses during one SEND: first becomes pending and its message starts after one idle cycle with subunit+1; second sets drop_err=1.
- In DONE, mission_start: subunit=0, mission_done=0, drop_err=0; rst_n asserted mid-SEND: tx_valid=0 and subunit=0 immediately, without waiting for a clock edge.
- RDM_TIMEOUT_EN with TIMEOUT_CYCLES=16, tx_ready held 0: after 16 stall cycles tx_timeout=1, RDM_active=0, subunit unchanged.
